regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Initiator side of the register-file access interface: converts single-beat operation requests from the control unit into cycle-exact rd/wn, stack and flag strobes for the register file.
- Captures the registered `read_data` one cycle after each read strobe and returns operands on a valid/ready response channel.
- Serialises all register-file traffic: at most one strobe group per cycle, one operation in flight.

Parameters:
- DATA_W, 16, width of register data
- REG_ADDR_W, 4, register index width
- SP_REG, 2, index of the stack-pointer register
- FLAG_W, 3, number of flag bits

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  3  operation: 000 NOP, 001 READ1, 010 READ2, 011 WRITE, 100 PUSH, 101 POP, 110 SETFLAGS, 111 reserved
- req_ra  in  REG_ADDR_W  first register index
- req_rb  in  REG_ADDR_W  second register index (READ2 only)
- req_wdata  in  DATA_W  write data (WRITE)
- req_flag_mask  in  FLAG_W  per-bit flag update mask (SETFLAGS)
- req_flags  in  FLAG_W  new flag values (SETFLAGS)
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes the response
- resp_a  out  DATA_W  first result
- resp_b  out  DATA_W  second result
- resp_err  out  1  reserved or NOP opcode
- rf_rd, rf_wn, rf_stack_en, rf_push_en, rf_pop_en  out  1 each  register-file strobes
- rf_flag_en  out  FLAG_W+1  {enable, mask}
- rf_flags_in  out  FLAG_W  flag values
- rf_reg_id  out  REG_ADDR_W  register index
- rf_write_data  out  DATA_W  write data
- rf_read_data  in  DATA_W  registered read data; valid the cycle after `rf_rd`

Behaviour:
- Reset
  - state IDLE.
  - All `rf_*` outputs 0; `resp_valid`, `resp_err`, `resp_a`, `resp_b` = 0.
  - `req_ready` = 0 while `reset` is high, 1 from the first cycle after.
- Reset mid-operation: the operation is discarded. No strobe is driven in the cycle after reset deasserts.
- Acceptance
  - `req_ready` = 1 only in IDLE.
  - In cycle T with `req_valid && req_ready`, all `req_*` fields are latched and the FSM leaves IDLE.
- Strobe rules
  - All `rf_*` strobes default to 0 in every state not listed below.
  - `rf_rd` and `rf_wn` are never 1 together.
  - `push_en` and `pop_en` are never 1 together.
- READ1
  - T+1 ISSUE_A: rd=1, reg_id=ra.
  - T+2 CAP_A: resp_a <= rf_read_data.
  - T+3 RESP.
- READ2
  - T+1 ISSUE_A: rd=1, reg_id=ra.
  - T+2 ISSUE_B: rd=1, reg_id=rb, and resp_a <= rf_read_data.
  - T+3 CAP_B: resp_b <= rf_read_data.
  - T+4 RESP.
- WRITE
  - T+1 WR: wn=1, reg_id=ra, write_data=wdata.
  - T+2 RESP; resp_a = wdata.
- PUSH
  - T+1 STK: stack_en=1, push_en=1.
  - T+2 ISSUE_A: rd=1, reg_id=SP_REG.
  - T+3 CAP_A.
  - T+4 RESP; resp_a = incremented SP.
- POP
  - T+1 POP: rd=1, reg_id=SP_REG, stack_en=1, pop_en=1. The register file reads before it decrements.
  - T+2 CAP_A.
  - T+3 RESP; resp_a = SP value before the decrement.
- SETFLAGS
  - T+1 FLG: rf_flag_en={1, mask}, rf_flags_in=flags.
  - T+2 RESP; resp_a = 0.
- NOP or 111: T+1 RESP with resp_err=1, no strobes.
- RESP state
  - `resp_valid` = 1; `resp_a`, `resp_b`, `resp_err` stay stable until `resp_ready`.
  - On `resp_ready`: next state IDLE, `resp_valid` = 0 the next cycle, `resp_err` cleared.
  - Minimum back-to-back spacing is therefore one IDLE cycle.
- Width rules
  - `resp_b` = 0 for every operation except READ2.
  - SP wrap-around (0xFFFF→0 on PUSH, 0→0xFFFF on POP) belongs to the register file. The sequencer returns the value read without any check.

Decomposition:
- Package `regfile_pkg`:
  - opcode constants (OP_NOP … OP_RSVD)
  - FSM state encoding (IDLE, ISSUE_A, ISSUE_B, CAP_A, CAP_B, WR, STK, POP, FLG, RESP)
  - SP_REG default
  - flag-enable field layout
- One module: a single FSM plus capture registers. No sub-module.

Test Plan:
- Reset held 3 cycles mid-READ2 → all rf strobes 0 the cycle after release; req_ready=1; resp_valid=0.
- WRITE R5=0x1234, then READ1 R5 → resp_a=0x1234, resp_err=0; READ1 resp_valid exactly 3 cycles after acceptance.
- WRITE R3=0xAAAA, R4=0x5555; READ2 ra=3, rb=4 → resp_a=0xAAAA, resp_b=0x5555; rf_rd high in T+1 and T+2 only.
- WRITE R2=0x0010; PUSH → resp_a=0x0011; then POP → resp_a=0x0011 and SP becomes 0x0010 (confirm with READ1 R2). Repeat with R2=0xFFFF: PUSH → resp_a=0x0000.
- SETFLAGS mask=101, flags=111 with flags previously 000 → rf_flag_en=4'b1101 for one cycle; register-file flags_out=101.
- req_op=111 → resp_err=1 at T+1, no strobes. Hold resp_ready=0 for 4 cycles → resp fields stable and req_ready=0 throughout.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states,
// default geometry and the layout of the flag-enable strobe field.
package regfile_pkg;

    // Default geometry; the top module exposes these as overridable parameters.
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_REG_ADDR_W = 4;
    localparam int DEF_SP_REG     = 2;
    localparam int DEF_FLAG_W     = 3;

    // rf_flag_en is {enable, mask}: the enable bit sits above the per-flag mask.
    localparam int DEF_FLAG_EN_W  = DEF_FLAG_W + 1;

    typedef enum logic [2:0] {
        OP_NOP      = 3'b000,
        OP_READ1    = 3'b001,
        OP_READ2    = 3'b010,
        OP_WRITE    = 3'b011,
        OP_PUSH     = 3'b100,
        OP_POP      = 3'b101,
        OP_SETFLAGS = 3'b110,
        OP_RSVD     = 3'b111
    } op_e;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ISSUE_A = 4'd1,
        ISSUE_B = 4'd2,
        CAP_A   = 4'd3,
        CAP_B   = 4'd4,
        WR      = 4'd5,
        STK     = 4'd6,
        POP     = 4'd7,
        FLG     = 4'd8,
        RESP    = 4'd9
    } state_e;

    // Opcodes that produce an error response without touching the register file.
    function automatic logic is_err_op(input logic [2:0] op);
        return (op == OP_NOP) || (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Request/response channel between the control unit and the sequencer.
interface regfile_sequencer_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int FLAG_W     = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [REG_ADDR_W-1:0] req_ra;
    logic [REG_ADDR_W-1:0] req_rb;
    logic [DATA_W-1:0]     req_wdata;
    logic [FLAG_W-1:0]     req_flag_mask;
    logic [FLAG_W-1:0]     req_flags;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_a;
    logic [DATA_W-1:0]     resp_b;
    logic                  resp_err;

    // Control-unit side.
    modport master (
        output req_valid, req_op, req_ra, req_rb, req_wdata, req_flag_mask, req_flags,
        output resp_ready,
        input  req_ready, resp_valid, resp_a, resp_b, resp_err
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_ra, req_rb, req_wdata, req_flag_mask, req_flags,
        input  resp_ready,
        output req_ready, resp_valid, resp_a, resp_b, resp_err
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Register-file sequencer: accepts one operation at a time, emits the
// cycle-exact strobe pattern for it, captures registered read data and
// returns the result on a valid/ready response channel.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int SP_REG     = DEF_SP_REG,
    parameter int FLAG_W     = DEF_FLAG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_sequencer_if.slave    bus,
    output logic                  rf_rd,
    output logic                  rf_wn,
    output logic                  rf_stack_en,
    output logic                  rf_push_en,
    output logic                  rf_pop_en,
    output logic [FLAG_W:0]       rf_flag_en,
    output logic [FLAG_W-1:0]     rf_flags_in,
    output logic [REG_ADDR_W-1:0] rf_reg_id,
    output logic [DATA_W-1:0]     rf_write_data,
    input  logic [DATA_W-1:0]     rf_read_data
);

    localparam logic [REG_ADDR_W-1:0] SP_ID = REG_ADDR_W'(SP_REG);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [REG_ADDR_W-1:0] ra_q, ra_d;
    logic [REG_ADDR_W-1:0] rb_q, rb_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [FLAG_W-1:0]     mask_q, mask_d;
    logic [FLAG_W-1:0]     flags_q, flags_d;
    logic [DATA_W-1:0]     resp_a_q, resp_a_d;
    logic [DATA_W-1:0]     resp_b_q, resp_b_d;
    logic                  resp_err_q, resp_err_d;
    logic                  accept;

    // Requests are only taken in IDLE, and never while reset is asserted.
    assign bus.req_ready  = (state_q == IDLE) && !reset;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_a     = resp_a_q;
    assign bus.resp_b     = resp_b_q;
    assign bus.resp_err   = resp_err_q;

    // Next-state, request latching, result capture and strobe generation.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ra_d          = ra_q;
        rb_d          = rb_q;
        wdata_d       = wdata_q;
        mask_d        = mask_q;
        flags_d       = flags_q;
        resp_a_d      = resp_a_q;
        resp_b_d      = resp_b_q;
        resp_err_d    = resp_err_q;
        rf_rd         = 1'b0;
        rf_wn         = 1'b0;
        rf_stack_en   = 1'b0;
        rf_push_en    = 1'b0;
        rf_pop_en     = 1'b0;
        rf_flag_en    = '0;
        rf_flags_in   = '0;
        rf_reg_id     = '0;
        rf_write_data = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d       = op_e'(bus.req_op);
                    ra_d       = bus.req_ra;
                    rb_d       = bus.req_rb;
                    wdata_d    = bus.req_wdata;
                    mask_d     = bus.req_flag_mask;
                    flags_d    = bus.req_flags;
                    resp_a_d   = '0;
                    resp_b_d   = '0;
                    resp_err_d = is_err_op(bus.req_op);
                    case (op_e'(bus.req_op))
                        OP_READ1, OP_READ2: state_d = ISSUE_A;
                        OP_WRITE:           state_d = WR;
                        OP_PUSH:            state_d = STK;
                        OP_POP:             state_d = POP;
                        OP_SETFLAGS:        state_d = FLG;
                        default:            state_d = RESP;
                    endcase
                end
            end
            ISSUE_A: begin
                // After a push, SP is re-read so the response carries the new value.
                rf_rd     = 1'b1;
                rf_reg_id = (op_q == OP_PUSH) ? SP_ID : ra_q;
                state_d   = (op_q == OP_READ2) ? ISSUE_B : CAP_A;
            end
            ISSUE_B: begin
                // Second read overlaps capture of the first read's data.
                rf_rd     = 1'b1;
                rf_reg_id = rb_q;
                resp_a_d  = rf_read_data;
                state_d   = CAP_B;
            end
            CAP_A: begin
                resp_a_d = rf_read_data;
                state_d  = RESP;
            end
            CAP_B: begin
                resp_b_d = rf_read_data;
                state_d  = RESP;
            end
            WR: begin
                rf_wn         = 1'b1;
                rf_reg_id     = ra_q;
                rf_write_data = wdata_q;
                resp_a_d      = wdata_q;
                state_d       = RESP;
            end
            STK: begin
                rf_stack_en = 1'b1;
                rf_push_en  = 1'b1;
                state_d     = ISSUE_A;
            end
            POP: begin
                // The register file reads SP before decrementing it.
                rf_rd       = 1'b1;
                rf_reg_id   = SP_ID;
                rf_stack_en = 1'b1;
                rf_pop_en   = 1'b1;
                state_d     = CAP_A;
            end
            FLG: begin
                rf_flag_en  = {1'b1, mask_q};
                rf_flags_in = flags_q;
                resp_a_d    = '0;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_err_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Nothing reaches the register file while reset is held.
        if (reset) begin
            rf_rd         = 1'b0;
            rf_wn         = 1'b0;
            rf_stack_en   = 1'b0;
            rf_push_en    = 1'b0;
            rf_pop_en     = 1'b0;
            rf_flag_en    = '0;
            rf_flags_in   = '0;
            rf_reg_id     = '0;
            rf_write_data = '0;
        end
    end

    // FSM state and response registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            resp_a_q   <= '0;
            resp_b_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_a_q   <= resp_a_d;
            resp_b_q   <= resp_b_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Latched request fields; only meaningful once an operation is accepted.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        ra_q    <= ra_d;
        rb_q    <= rb_d;
        wdata_q <= wdata_d;
        mask_q  <= mask_d;
        flags_q <= flags_d;
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register-file model.
module tb_regfile_sequencer;
    import regfile_pkg::*;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int SP_REG     = 2;
    localparam int FLAG_W     = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_sequencer_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .FLAG_W(FLAG_W)) bus ();

    logic                  rf_rd, rf_wn, rf_stack_en, rf_push_en, rf_pop_en;
    logic [FLAG_W:0]       rf_flag_en;
    logic [FLAG_W-1:0]     rf_flags_in;
    logic [REG_ADDR_W-1:0] rf_reg_id;
    logic [DATA_W-1:0]     rf_write_data;
    logic [DATA_W-1:0]     rf_read_data = '0;

    regfile_sequencer #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .SP_REG(SP_REG), .FLAG_W(FLAG_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .rf_rd(rf_rd), .rf_wn(rf_wn), .rf_stack_en(rf_stack_en),
        .rf_push_en(rf_push_en), .rf_pop_en(rf_pop_en), .rf_flag_en(rf_flag_en),
        .rf_flags_in(rf_flags_in), .rf_reg_id(rf_reg_id), .rf_write_data(rf_write_data),
        .rf_read_data(rf_read_data)
    );

    // Register-file model: registered reads, SP push/pop, masked flag update.
    logic [DATA_W-1:0] regs [16] = '{default: '0};
    logic [FLAG_W-1:0] flags_out = '0;
    always @(posedge clk) begin
        if (rf_wn) regs[rf_reg_id] <= rf_write_data;
        if (rf_rd) rf_read_data <= regs[rf_reg_id];
        if (rf_stack_en && rf_push_en) regs[SP_REG] <= regs[SP_REG] + 16'd1;
        else if (rf_stack_en && rf_pop_en) regs[SP_REG] <= regs[SP_REG] - 16'd1;
        if (rf_flag_en[FLAG_W])
            flags_out <= (flags_out & ~rf_flag_en[FLAG_W-1:0]) | (rf_flags_in & rf_flag_en[FLAG_W-1:0]);
    end

    // Illegal strobe combinations seen on any edge.
    int excl_viol = 0;
    always @(posedge clk) begin
        if ((rf_rd && rf_wn) || (rf_push_en && rf_pop_en)) excl_viol <= excl_viol + 1;
    end

    wire [31:0] strobes = {rf_rd, rf_wn, rf_stack_en, rf_push_en, rf_pop_en,
                           rf_flag_en, rf_flags_in, rf_reg_id, rf_write_data};

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE; rd_m/wn_m/stk_m bit i is the strobe at T+i.
    task automatic do_op(
        input  logic [2:0]  op,
        input  logic [3:0]  ra,
        input  logic [3:0]  rb,
        input  logic [15:0] wd,
        input  logic [2:0]  mask,
        input  logic [2:0]  flg,
        input  int          hold,
        output logic [15:0] a,
        output logic [15:0] b,
        output logic        err,
        output int          lat,
        output logic [7:0]  rd_m,
        output logic [7:0]  wn_m,
        output logic [7:0]  stk_m,
        output logic [3:0]  fe1,
        output int          fe_cnt
    );
        bus.req_valid     = 1'b1;
        bus.req_op        = op;
        bus.req_ra        = ra;
        bus.req_rb        = rb;
        bus.req_wdata     = wd;
        bus.req_flag_mask = mask;
        bus.req_flags     = flg;
        tick();
        bus.req_valid = 1'b0;
        lat = 1; rd_m = '0; wn_m = '0; stk_m = '0; fe1 = '0; fe_cnt = 0;
        while (!bus.resp_valid && lat < 20) begin
            if (lat < 8) begin
                rd_m[lat]  = rf_rd;
                wn_m[lat]  = rf_wn;
                stk_m[lat] = rf_stack_en;
            end
            if (lat == 1) fe1 = rf_flag_en;
            if (rf_flag_en != '0) fe_cnt++;
            tick();
            lat++;
        end
        check("resp_valid_arrives", {31'd0, bus.resp_valid}, 32'd1);
        a   = bus.resp_a;
        b   = bus.resp_b;
        err = bus.resp_err;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("hold_req_ready",  {31'd0, bus.req_ready}, 32'd0);
            check("hold_resp_a",     {16'd0, bus.resp_a}, {16'd0, a});
            check("hold_resp_b",     {16'd0, bus.resp_b}, {16'd0, b});
            check("hold_resp_err",   {31'd0, bus.resp_err}, {31'd0, err});
            check("hold_strobes",    strobes, 32'd0);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("resp_valid_drop", {31'd0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b;
        logic        err;
        int          lat, fec;
        logic [7:0]  rdm, wnm, stkm;
        logic [3:0]  fe1;

        bus.req_valid = 0; bus.req_op = 0; bus.req_ra = 0; bus.req_rb = 0;
        bus.req_wdata = 0; bus.req_flag_mask = 0; bus.req_flags = 0; bus.resp_ready = 0;

        // Power-on reset.
        reset = 1'b1;
        repeat (3) tick();
        check("rst_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
        check("rst_strobes", strobes, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("post_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("post_rst_resp_a", {16'd0, bus.resp_a}, 32'd0);
        check("post_rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("post_rst_strobes", strobes, 32'd0);

        // WRITE R5 then READ1 R5.
        do_op(OP_WRITE, 4'd5, 4'd0, 16'h1234, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("wr5_resp_a", {16'd0, a}, 32'h1234);
        check("wr5_lat", lat, 2);
        check("wr5_wn_mask", {24'd0, wnm}, 32'h02);
        check("wr5_rf_reg5", {16'd0, regs[5]}, 32'h1234);
        do_op(OP_READ1, 4'd5, 4'd0, 16'h0, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("rd5_resp_a", {16'd0, a}, 32'h1234);
        check("rd5_resp_b", {16'd0, b}, 32'h0);
        check("rd5_err", {31'd0, err}, 32'd0);
        check("rd5_lat", lat, 3);
        check("rd5_rd_mask", {24'd0, rdm}, 32'h02);

        // READ2 of R3/R4.
        do_op(OP_WRITE, 4'd3, 4'd0, 16'hAAAA, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        do_op(OP_WRITE, 4'd4, 4'd0, 16'h5555, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        do_op(OP_READ2, 4'd3, 4'd4, 16'h0, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("rd2_resp_a", {16'd0, a}, 32'hAAAA);
        check("rd2_resp_b", {16'd0, b}, 32'h5555);
        check("rd2_lat", lat, 4);
        check("rd2_rd_mask", {24'd0, rdm}, 32'h06);

        // PUSH / POP around SP = 0x0010.
        do_op(OP_WRITE, 4'd2, 4'd0, 16'h0010, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        do_op(OP_PUSH, 4'd0, 4'd0, 16'h0, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("push_resp_a", {16'd0, a}, 32'h0011);
        check("push_lat", lat, 4);
        check("push_stk_mask", {24'd0, stkm}, 32'h02);
        check("push_rd_mask", {24'd0, rdm}, 32'h04);
        do_op(OP_POP, 4'd0, 4'd0, 16'h0, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("pop_resp_a", {16'd0, a}, 32'h0011);
        check("pop_lat", lat, 3);
        check("pop_stk_mask", {24'd0, stkm}, 32'h02);
        check("pop_rd_mask", {24'd0, rdm}, 32'h02);
        do_op(OP_READ1, 4'd2, 4'd0, 16'h0, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("sp_after_pop", {16'd0, a}, 32'h0010);

        // PUSH with SP wrapping from 0xFFFF.
        do_op(OP_WRITE, 4'd2, 4'd0, 16'hFFFF, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        do_op(OP_PUSH, 4'd0, 4'd0, 16'h0, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("push_wrap_resp_a", {16'd0, a}, 32'h0000);

        // SETFLAGS mask=101 flags=111 from 000.
        do_op(OP_SETFLAGS, 4'd0, 4'd0, 16'h0, 3'b101, 3'b111, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("flg_flag_en", {28'd0, fe1}, 32'hD);
        check("flg_en_cycles", fec, 1);
        check("flg_flags_out", {29'd0, flags_out}, 32'h5);
        check("flg_resp_a", {16'd0, a}, 32'h0);
        check("flg_lat", lat, 2);

        // Reserved opcode, response held for 4 cycles.
        do_op(OP_RSVD, 4'd1, 4'd1, 16'h0, 3'd0, 3'd0, 4, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("rsvd_err", {31'd0, err}, 32'd1);
        check("rsvd_lat", lat, 1);
        check("rsvd_resp_a", {16'd0, a}, 32'h0);
        check("rsvd_err_cleared", {31'd0, bus.resp_err}, 32'd0);
        do_op(OP_NOP, 4'd0, 4'd0, 16'h0, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("nop_err", {31'd0, err}, 32'd1);
        check("nop_lat", lat, 1);

        // Reset held 3 cycles in the middle of a READ2.
        bus.req_valid = 1'b1; bus.req_op = OP_READ2; bus.req_ra = 4'd3; bus.req_rb = 4'd4;
        tick();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("midrst_strobes", strobes, 32'd0);
        check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        tick();
        check("midrst_strobes_next", strobes, 32'd0);
        check("midrst_resp_valid_next", {31'd0, bus.resp_valid}, 32'd0);
        do_op(OP_READ1, 4'd4, 4'd0, 16'h0, 3'd0, 3'd0, 0, a, b, err, lat, rdm, wnm, stkm, fe1, fec);
        check("after_rst_read_r4", {16'd0, a}, 32'h5555);

        check("strobe_exclusivity", excl_viol, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
